multi_cycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 9-bit top level.
- Fetches from an external combinational instruction ROM and executes the 9-bit ISA over an 8-entry register file.
- Reaches data memory through a req/ack handshake with arbitrary latency, raises `done` on a HALT instruction, and counts retired instructions.
- Sits as the CPU core under the chip top, replacing the flat single-cycle datapath.

---
 rtl/multi_cycle_core.sv | 151 +++++++++++++++
 tb/tb_multi_cycle_core.sv | 603 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle 9-bit ISA core with an 8-entry register file.
// Ports: clk, reset (async active-low), instr_addr/instr_data (combinational ROM),
//   dmem_req/we/addr/wdata/rdata/ack (req/ack data memory), done, instr_count.
module multi_cycle_core #(
   parameter int DW   = 8,
   parameter int PCW  = 10,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PCW-1:0]  instr_addr,
   input  logic [8:0]      instr_data,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [DW-1:0]   dmem_addr,
   output logic [DW-1:0]   dmem_wdata,
   input  logic [DW-1:0]   dmem_rdata,
   input  logic            dmem_ack,
   output logic            done,
   output logic [CNTW-1:0] instr_count
);

   typedef enum logic [1:0] {
      FETCH,
      EXEC,
      MEM,
      HALT
   } state_t;

   state_t         state;
   logic [PCW-1:0] pc;
   logic [8:0]     ir;
   logic [DW-1:0]  regs [8];

   logic [2:0]      op;
   logic [2:0]      rd;
   logic [2:0]      rs;
   logic [5:0]      imm;
   logic [DW-1:0]   a;
   logic [DW-1:0]   b;
   logic [DW-1:0]   alu_y;
   logic [PCW-1:0]  target;
   logic [CNTW-1:0] cnt_inc;
   logic            is_alu;
   logic            is_mem;
   logic            is_halt;
   logic            is_br;
   logic            taken;

   assign op  = ir[8:6];
   assign rd  = ir[5:3];
   assign rs  = ir[2:0];
   assign imm = ir[5:0];
   assign a   = regs[rd];
   assign b   = regs[rs];

   assign instr_addr = pc;

   assign is_alu  = ~op[2];
   assign is_mem  = (op[2:1] == 2'b10);
   assign is_halt = (op == 3'b111) && (imm == 6'h3F);
   assign is_br   = (op[2:1] == 2'b11) && !is_halt;

   // JMP always taken; BZ only when R0 is zero
   assign taken = op[0] || (regs[0] == '0);

   assign cnt_inc = (instr_count == '1) ? instr_count
                                        : instr_count + 1'b1;

   // imm zero-extends; bits beyond PCW are dropped on narrow builds
   always_comb begin
      target = '0;
      for (int i = 0; i < PCW && i < 6; i++)
         target[i] = imm[i];
   end

   always_comb begin
      alu_y = '0;
      unique case (op[1:0])
         2'b00: alu_y = a + b;
         2'b01: alu_y = a - b;
         2'b10: alu_y = a & b;
         2'b11: alu_y = a ^ b;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= '0;
         ir          <= '0;
         for (int i = 0; i < 8; i++)
            regs[i] <= '0;
         done        <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         instr_count <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               ir    <= instr_data;
               pc    <= pc + 1'b1;
               state <= EXEC;
            end
            EXEC: begin
               unique case (1'b1)
                  is_alu: begin
                     regs[rd]    <= alu_y;
                     instr_count <= cnt_inc;
                     state       <= FETCH;
                  end
                  is_mem: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= op[0];
                     dmem_addr  <= b;
                     dmem_wdata <= a;
                     state      <= MEM;
                  end
                  is_halt: begin
                     instr_count <= cnt_inc;
                     done        <= 1'b1;
                     state       <= HALT;
                  end
                  is_br: begin
                     if (taken)
                        pc <= target;
                     instr_count <= cnt_inc;
                     state       <= FETCH;
                  end
                  default: state <= FETCH;
               endcase
            end
            MEM: begin
               if (dmem_ack) begin
                  if (!dmem_we)
                     regs[rd] <= dmem_rdata;
                  dmem_req    <= 1'b0;
                  instr_count <= cnt_inc;
                  state       <= FETCH;
               end
            end
            HALT: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: directed and randomized checks of multi_cycle_core
// against an instruction-level reference model.
module tb_multi_cycle_core;

   logic        clk;
   logic        reset;
   logic [9:0]  instr_addr;
   logic [8:0]  instr_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [7:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic [7:0]  dmem_rdata;
   logic        dmem_ack;
   logic        done;
   logic [15:0] instr_count;

   logic        reset_s;
   logic [3:0]  instr_addr_s;
   logic [8:0]  instr_data_s;
   logic        dmem_req_s;
   logic        dmem_we_s;
   logic [7:0]  dmem_addr_s;
   logic [7:0]  dmem_wdata_s;
   logic        zero_ack;
   logic [7:0]  zero_data;
   logic        done_s;
   logic [2:0]  count_s;

   logic [8:0]  rom   [0:1023];
   logic [8:0]  rom_s [0:15];
   logic [7:0]  mem   [0:255];
   logic [7:0]  m_mem [0:255];
   logic [7:0]  m_regs [0:7];
   int          lat_tab [0:255];

   logic        auto_mem;
   logic        r_ack;
   logic [7:0]  r_rdata;
   logic        m_ack;
   logic [7:0]  m_rdata;
   logic        busy;
   int          rem;
   int          lat_idx;
   int          stab_err;
   logic [16:0] cap;
   logic [16:0] dut_ops [$];
   logic [16:0] exp_ops [$];

   int errors;
   int checks;

   assign instr_data   = rom[instr_addr];
   assign instr_data_s = rom_s[instr_addr_s];
   assign dmem_ack     = auto_mem ? r_ack : m_ack;
   assign dmem_rdata   = auto_mem ? r_rdata : m_rdata;
   assign zero_ack     = 1'b0;
   assign zero_data    = 8'h00;

   multi_cycle_core dut (
      .clk         (clk),
      .reset       (reset),
      .instr_addr  (instr_addr),
      .instr_data  (instr_data),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_ack    (dmem_ack),
      .done        (done),
      .instr_count (instr_count)
   );

   multi_cycle_core #(.DW(8), .PCW(4), .CNTW(3)) dut_s (
      .clk         (clk),
      .reset       (reset_s),
      .instr_addr  (instr_addr_s),
      .instr_data  (instr_data_s),
      .dmem_req    (dmem_req_s),
      .dmem_we     (dmem_we_s),
      .dmem_addr   (dmem_addr_s),
      .dmem_wdata  (dmem_wdata_s),
      .dmem_rdata  (zero_data),
      .dmem_ack    (zero_ack),
      .done        (done_s),
      .instr_count (count_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory responder: ack after lat_tab[n] MEM cycles for the n-th request
   initial begin
      busy     = 1'b0;
      rem      = 0;
      lat_idx  = 0;
      stab_err = 0;
      cap      = '0;
      r_ack    = 1'b0;
      r_rdata  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         r_ack = 1'b0;
         if (!reset) begin
            busy     = 1'b0;
            lat_idx  = 0;
            stab_err = 0;
            dut_ops.delete();
         end else if (auto_mem) begin
            if (dmem_req && !busy) begin
               busy = 1'b1;
               rem  = lat_tab[lat_idx];
               lat_idx++;
               cap  = {dmem_we, dmem_addr, dmem_wdata};
               dut_ops.push_back(cap);
            end
            if (busy) begin
               if (!dmem_req || {dmem_we, dmem_addr, dmem_wdata} !== cap)
                  stab_err++;
               rem--;
               if (rem == 0) begin
                  r_ack = 1'b1;
                  if (cap[16])
                     mem[cap[15:8]] = cap[7:0];
                  else
                     r_rdata = mem[cap[15:8]];
                  busy = 1'b0;
               end
            end
         end
      end
   end

   function automatic logic [8:0] ins(input int op, input int rd, input int rs);
      logic [2:0] o, d, s;
      o = op[2:0];
      d = rd[2:0];
      s = rs[2:0];
      return {o, d, s};
   endfunction

   function automatic logic [8:0] br(input int op, input int imm);
      logic [2:0] o;
      logic [5:0] i;
      o = op[2:0];
      i = imm[5:0];
      return {o, i};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic init_tb();
      auto_mem = 1'b1;
      m_ack    = 1'b0;
      m_rdata  = 8'h00;
      for (int i = 0; i < 1024; i++) rom[i] = 9'h1FF;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'h00;
         lat_tab[i] = 1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   task automatic run_to_done(input int max, output int cyc, output bit to);
      cyc = 0;
      while (!done && cyc < max) begin
         tick();
         cyc++;
      end
      to = !done;
   endtask

   // instruction-level model: executes until HALT, logging memory requests
   task automatic model_run(output int cyc, output int cnt);
      int pc, midx, a, b;
      logic [8:0] w;
      logic [2:0] op, rd, rs;
      logic [5:0] imm;
      pc = 0; midx = 0; cyc = 0; cnt = 0;
      for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
      exp_ops.delete();
      for (int s = 0; s < 1000; s++) begin
         w   = rom[pc];
         pc  = (pc + 1) % 1024;
         op  = w[8:6];
         rd  = w[5:3];
         rs  = w[2:0];
         imm = w[5:0];
         a   = int'(m_regs[rd]);
         b   = int'(m_regs[rs]);
         cyc += 2;
         cnt++;
         case (op)
            3'd0: m_regs[rd] = 8'((a + b) % 256);
            3'd1: m_regs[rd] = 8'((a - b + 256) % 256);
            3'd2: m_regs[rd] = 8'(a & b);
            3'd3: m_regs[rd] = 8'(a ^ b);
            3'd4: begin
               exp_ops.push_back({1'b0, 8'(b), 8'(a)});
               cyc += lat_tab[midx];
               midx++;
               m_regs[rd] = m_mem[b];
            end
            3'd5: begin
               exp_ops.push_back({1'b1, 8'(b), 8'(a)});
               cyc += lat_tab[midx];
               midx++;
               m_mem[b] = 8'(a);
            end
            3'd6: if (m_regs[0] == 8'h00) pc = int'(imm);
            default: begin
               if (imm == 6'h3F) break;
               pc = int'(imm);
            end
         endcase
      end
   endtask

   task automatic test_reset();
      init_tb();
      reset_s = 1'b0;
      mem[0]     = 8'h3C;
      lat_tab[1] = 4;
      rom[0] = ins(4, 1, 0);
      rom[1] = ins(5, 1, 1);
      do_reset();
      repeat (5) tick();
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 8'h3C, 8'h3C}) begin
         errors++;
         $display("FAIL pre_reset_st: got %h want %h",
                  {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {2'b11, 8'h3C, 8'h3C});
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 18'h0) begin
         errors++;
         $display("FAIL reset_dmem: got %h want 0",
                  {dmem_req, dmem_we, dmem_addr, dmem_wdata});
      end
      checks++;
      if ({instr_addr, done, instr_count} !== 27'h0) begin
         errors++;
         $display("FAIL reset_core: pc %h done %b cnt %h want 0",
                  instr_addr, done, instr_count);
      end
      checks++;
      if ({instr_addr_s, done_s, count_s, dmem_req_s} !== 9'h0) begin
         errors++;
         $display("FAIL reset_small: pc %h done %b cnt %h req %b want 0",
                  instr_addr_s, done_s, count_s, dmem_req_s);
      end
   endtask

   task automatic test_alu();
      int cyc;
      bit to;
      logic [16:0] want [4];
      init_tb();
      mem[0] = 8'h01;
      rom[0] = ins(3, 1, 1);
      rom[1] = ins(1, 1, 0);
      rom[2] = ins(0, 1, 1);
      rom[3] = ins(4, 0, 7);
      rom[4] = ins(1, 1, 0);
      rom[5] = ins(5, 1, 7);
      rom[6] = ins(0, 1, 1);
      rom[7] = ins(5, 1, 0);
      rom[8] = ins(3, 1, 0);
      rom[9] = ins(5, 1, 0);
      want[0] = {1'b0, 8'h00, 8'h00};
      want[1] = {1'b1, 8'h00, 8'hFF};
      want[2] = {1'b1, 8'h01, 8'hFE};
      want[3] = {1'b1, 8'h01, 8'hFF};
      do_reset();
      repeat (6) tick();
      checks++;
      if (instr_count !== 16'd3 || instr_addr !== 10'd3) begin
         errors++;
         $display("FAIL alu_6cyc: cnt %0d pc %0d want 3 3", instr_count, instr_addr);
      end
      run_to_done(200, cyc, to);
      checks++;
      if (to || instr_count !== 16'd11) begin
         errors++;
         $display("FAIL alu_done: timeout %b cnt %0d want 0 11", to, instr_count);
      end
      checks++;
      if (dut_ops.size() != 4) begin
         errors++;
         $display("FAIL alu_nops: got %0d want 4", dut_ops.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_ops[i] !== want[i]) begin
               errors++;
               $display("FAIL alu_op%0d: got %h want %h", i, dut_ops[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_mem();
      int cyc;
      bit to;
      init_tb();
      mem[0]     = 8'h5A;
      mem[8'h5A] = 8'h10;
      lat_tab[0] = 3;
      rom[0] = ins(4, 2, 0);
      rom[1] = ins(4, 3, 2);
      rom[2] = ins(5, 2, 3);
      do_reset();
      tick();
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL ld_req_fetch: got %b want 0", dmem_req);
      end
      for (int k = 2; k <= 4; k++) begin
         tick();
         checks++;
         if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 8'h00}
             || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL ld_req_cyc%0d: req %b we %b addr %h cnt %0d want 1 0 00 0",
                     k, dmem_req, dmem_we, dmem_addr, instr_count);
         end
      end
      tick();
      checks++;
      if (dmem_req !== 1'b0 || instr_count !== 16'd1) begin
         errors++;
         $display("FAIL ld_end: req %b cnt %0d want 0 1", dmem_req, instr_count);
      end
      run_to_done(200, cyc, to);
      checks++;
      if (to || cyc != 8 || instr_count !== 16'd4) begin
         errors++;
         $display("FAIL mem_tail: to %b cyc %0d cnt %0d want 0 8 4", to, cyc, instr_count);
      end
      checks++;
      if (dut_ops.size() != 3) begin
         errors++;
         $display("FAIL mem_nops: got %0d want 3", dut_ops.size());
      end else begin
         checks++;
         if (dut_ops[1] !== {1'b0, 8'h5A, 8'h00}) begin
            errors++;
            $display("FAIL mem_ld2: got %h want 05a00", dut_ops[1]);
         end
         checks++;
         if (dut_ops[2] !== {1'b1, 8'h10, 8'h5A}) begin
            errors++;
            $display("FAIL mem_st: got %h want 1105a", dut_ops[2]);
         end
      end
   endtask

   task automatic test_branch();
      bit frozen;
      init_tb();
      rom[0] = br(6, 8);
      do_reset();
      repeat (2) tick();
      checks++;
      if (instr_addr !== 10'd8) begin
         errors++;
         $display("FAIL bz_taken: pc %0d want 8", instr_addr);
      end
      init_tb();
      mem[0] = 8'h01;
      rom[0] = ins(4, 0, 0);
      rom[1] = br(6, 8);
      rom[2] = br(7, 63);
      do_reset();
      repeat (5) tick();
      checks++;
      if (instr_addr !== 10'd2) begin
         errors++;
         $display("FAIL bz_not_taken: pc %0d want 2", instr_addr);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL halt_early: done %b want 0", done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || instr_addr !== 10'd3 || instr_count !== 16'd3) begin
         errors++;
         $display("FAIL halt: done %b pc %0d cnt %0d want 1 3 3",
                  done, instr_addr, instr_count);
      end
      frozen = 1'b1;
      repeat (20) begin
         tick();
         if (done !== 1'b1 || instr_addr !== 10'd3
             || instr_count !== 16'd3 || dmem_req !== 1'b0)
            frozen = 1'b0;
      end
      checks++;
      if (!frozen) begin
         errors++;
         $display("FAIL halt_frozen: pc %0d cnt %0d done %b want 3 3 1",
                  instr_addr, instr_count, done);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) rom_s[i] = ins(0, 0, 0);
      reset_s = 1'b0;
      @(posedge clk);
      #2 reset_s = 1'b1;
      repeat (30) tick();
      checks++;
      if (instr_addr_s !== 4'd15) begin
         errors++;
         $display("FAIL wrap_pre: pc %0d want 15", instr_addr_s);
      end
      tick();
      checks++;
      if (instr_addr_s !== 4'd0) begin
         errors++;
         $display("FAIL wrap: pc %0d want 0", instr_addr_s);
      end
      checks++;
      if ({dmem_req_s, dmem_we_s, dmem_addr_s, dmem_wdata_s, done_s} !== 19'h0) begin
         errors++;
         $display("FAIL wrap_quiet: got %h want 0",
                  {dmem_req_s, dmem_we_s, dmem_addr_s, dmem_wdata_s, done_s});
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) rom_s[i] = ins(0, 0, 0);
      rom_s[9] = br(7, 0);
      reset_s = 1'b0;
      @(posedge clk);
      #2 reset_s = 1'b1;
      repeat (12) tick();
      checks++;
      if (count_s !== 3'd6) begin
         errors++;
         $display("FAIL sat_6: cnt %0d want 6", count_s);
      end
      repeat (2) tick();
      checks++;
      if (count_s !== 3'd7) begin
         errors++;
         $display("FAIL sat_7: cnt %0d want 7", count_s);
      end
      repeat (26) tick();
      checks++;
      if (count_s !== 3'd7 || instr_addr_s !== 4'd0) begin
         errors++;
         $display("FAIL sat_stick: cnt %0d pc %0d want 7 0", count_s, instr_addr_s);
      end
   endtask

   task automatic test_reset_abort();
      init_tb();
      auto_mem = 1'b0;
      rom[0] = ins(4, 1, 0);
      do_reset();
      repeat (3) tick();
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL abort_req: got %b want 1", dmem_req);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_drop: req %b want 0", dmem_req);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      m_ack   = 1'b1;
      m_rdata = 8'h77;
      tick();
      m_ack = 1'b0;
      checks++;
      if (instr_addr !== 10'd1 || instr_count !== 16'd0 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL abort_restart: pc %0d cnt %0d req %b want 1 0 0",
                  instr_addr, instr_count, dmem_req);
      end
      tick();
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 8'h00 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_reexec: req %b addr %h cnt %0d want 1 00 0",
                  dmem_req, dmem_addr, instr_count);
      end
      m_ack   = 1'b1;
      m_rdata = 8'h33;
      tick();
      m_ack = 1'b0;
      repeat (2) tick();
      checks++;
      if (instr_count !== 16'd2 || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_finish: cnt %0d done %b want 2 1", instr_count, done);
      end
   endtask

   task automatic test_random();
      int L, cyc, ecyc, ecnt, r, t, n;
      bit to;
      L = 24;
      for (int it = 0; it < 6; it++) begin
         init_tb();
         for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            m_mem[i]   = mem[i];
            lat_tab[i] = int'($urandom_range(1, 4));
         end
         for (int p = 0; p < L; p++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)
               rom[p] = ins(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)));
            else if (r < 9)
               rom[p] = ins((r < 7) ? 4 : 5, int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)));
            else begin
               t = p + 1 + int'($urandom_range(0, 3));
               if (t > L) t = L;
               rom[p] = br(int'($urandom_range(6, 7)), t);
            end
         end
         rom[L] = ins(3, 7, 7);
         for (int x = 0; x < 7; x++) rom[L + 1 + x] = ins(5, x, 7);
         rom[L + 8] = br(7, 63);
         model_run(ecyc, ecnt);
         do_reset();
         run_to_done(2000, cyc, to);
         checks++;
         if (to || cyc != ecyc || int'(instr_count) != ecnt) begin
            errors++;
            $display("FAIL rnd%0d_timing: to %b cyc %0d cnt %0d want 0 %0d %0d",
                     it, to, cyc, instr_count, ecyc, ecnt);
         end
         checks++;
         if (stab_err != 0) begin
            errors++;
            $display("FAIL rnd%0d_stable: got %0d unstable MEM cycles want 0", it, stab_err);
         end
         checks++;
         if (dut_ops.size() != exp_ops.size()) begin
            errors++;
            $display("FAIL rnd%0d_nops: got %0d want %0d", it, dut_ops.size(), exp_ops.size());
         end
         n = (dut_ops.size() < exp_ops.size()) ? dut_ops.size() : exp_ops.size();
         for (int i = 0; i < n; i++) begin
            checks++;
            if (dut_ops[i] !== exp_ops[i]) begin
               errors++;
               $display("FAIL rnd%0d_op%0d: got %h want %h", it, i, dut_ops[i], exp_ops[i]);
            end
         end
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      reset    = 1'b0;
      reset_s  = 1'b0;
      auto_mem = 1'b1;
      m_ack    = 1'b0;
      m_rdata  = 8'h00;
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_wrap();
      test_saturate();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
